// File: rtl/apb_rr_master_arbiter.sv
// apb_rr_master_arbiter
//
// Purpose: shares one APB master port among NUM_REQ requesters using round-robin arbitration.
// Each requester issues single read/write transactions on a valid/ready request channel and
// receives a one-cycle, one-hot response pulse. Only one transaction is in flight at a time,
// and the FSM sequences it through IDLE -> SETUP -> ACCESS -> RESP.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES
// cycles without pready_i. The abort returns rsp_err_o=1 and rsp_rdata_o=0. Without the macro,
// ACCESS waits on pready_i indefinitely.
//
// Ports:
//   clk_i, rst_i            clock (posedge) and synchronous active-high reset
//   req_valid_i/req_ready_o per-requester request handshake; ready is a one-hot accept pulse
//   req_write_i             per-requester direction (1 = write)
//   req_addr_i/req_wdata_i  flattened per-requester address / write data (slice k = requester k)
//   rsp_valid_o             one-hot response pulse
//   rsp_rdata_o/rsp_err_o   response payload, zero whenever rsp_valid_o is zero
//   paddr_o .. penable_o    APB master outputs
//   prdata_i/pready_i/pslverr_i  APB slave returns

module apb_rr_master_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ-1:0]        req_write_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic [ADDR_W-1:0]         paddr_o,
   output logic [DATA_W-1:0]         pwdata_o,
   output logic                      pwrite_o,
   output logic                      psel_o,
   output logic                      penable_o,
   input  logic [DATA_W-1:0]         prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned SumW = IdxW + 1;

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 16-bit timeout counter");
   end

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [IdxW-1:0]   id_q, id_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              win_found;
   logic [IdxW-1:0]   win_idx;
   logic [SumW-1:0]   cand_sum;
   logic [IdxW-1:0]   cand;

`ifdef APB_ARB_TIMEOUT_EN
   logic [15:0]       tmo_q, tmo_d;
`endif

   // Round-robin search: first valid requester at or after the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_sum  = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand_sum = {1'b0, ptr_q} + SumW'(i);
         if (cand_sum >= SumW'(NUM_REQ)) begin
            cand_sum = cand_sum - SumW'(NUM_REQ);
         end
         cand = cand_sum[IdxW-1:0];
         if (!win_found && req_valid_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state logic and the grant pulse.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      write_d     = write_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      req_ready_o = '0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif

      case (state_q)
         StIdle: begin
            // A grant during reset would be lost when the state is cleared, so hold it off.
            if (win_found && !rst_i) begin
               req_ready_o[win_idx] = 1'b1;
               id_d    = win_idx;
               addr_d  = req_addr_i[win_idx*ADDR_W +: ADDR_W];
               write_d = req_write_i[win_idx];
               wdata_d = req_write_i[win_idx] ? req_wdata_i[win_idx*DATA_W +: DATA_W] : '0;
               rdata_d = '0;
               err_d   = 1'b0;
               ptr_d   = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
               state_d = StSetup;
            end
         end
         StSetup: begin
            state_d = StAccess;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         StAccess: begin
            if (pready_i) begin
               rdata_d = write_q ? '0 : prdata_i;
               err_d   = pslverr_i;
               state_d = StResp;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else begin
               tmo_d = tmo_q + 16'd1;
               if (tmo_d == 16'(TIMEOUT_CYCLES)) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = StResp;
               end
            end
`endif
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // APB and response outputs are decoded straight from the state and the captured fields.
   always_comb begin
      psel_o      = 1'b0;
      penable_o   = 1'b0;
      paddr_o     = '0;
      pwdata_o    = '0;
      pwrite_o    = 1'b0;
      rsp_valid_o = '0;
      rsp_rdata_o = '0;
      rsp_err_o   = 1'b0;
      case (state_q)
         StSetup, StAccess: begin
            psel_o    = 1'b1;
            penable_o = (state_q == StAccess);
            paddr_o   = addr_q;
            pwdata_o  = wdata_q;
            pwrite_o  = write_q;
         end
         StResp: begin
            rsp_valid_o[id_q] = 1'b1;
            rsp_rdata_o       = rdata_q;
            rsp_err_o         = err_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         id_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Scoreboard bench for apb_rr_master_arbiter: directed transactions push expected grants,
// APB phases and responses into queues; independent negedge monitors pop and compare.
// The timeout scenario is included only when APB_ARB_TIMEOUT_EN is defined.

module tb_apb_rr_master_arbiter;

   localparam int NR  = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [DW-1:0]     rsp_rdata, pwdata, prdata = '0;
   logic              rsp_err, pwrite, psel, penable;
   logic              pready = 1'b0, pslverr = 1'b0;
   logic [AW-1:0]     paddr;

   apb_rr_master_arbiter #(
      .NUM_REQ        (NR),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .paddr_o     (paddr),
      .pwdata_o    (pwdata),
      .pwrite_o    (pwrite),
      .psel_o      (psel),
      .penable_o   (penable),
      .prdata_i    (prdata),
      .pready_i    (pready),
      .pslverr_i   (pslverr)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Expectation queues
   typedef struct { int id; int cyc; } gnt_t;
   typedef struct { int id; logic [31:0] rdata; logic err; int cyc; } rsp_t;
   typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } apb_t;
   gnt_t exp_gnt[$];
   rsp_t exp_rsp[$];
   apb_t exp_apb[$];

   // Requester model: valid stays high while issued transactions are not yet accepted.
   int issued[NR]   = '{default: 0};
   int accepted[NR] = '{default: 0};
   int acc_q[NR]    = '{default: 0};
   always @(posedge clk) acc_q <= accepted;
   always_comb begin
      for (int k = 0; k < NR; k++) req_valid[k] = (issued[k] > acc_q[k]);
   end

   // APB slave model: ready after ws wait states; garbage read data until ready.
   int          ws = 0;
   logic [31:0] slv_rdata = '0;
   logic        slv_err = 1'b0;
   int          acc_n = 0;
   always @(negedge clk) begin
      if (psel && penable) begin
         pready  = (acc_n == ws);
         prdata  = pready ? slv_rdata : 32'hBAD0_BAD0;
         pslverr = pready ? slv_err : 1'b0;
         acc_n   = acc_n + 1;
      end else begin
         acc_n   = 0;
         pready  = 1'b0;
         prdata  = 32'hBAD0_BAD0;
         pslverr = 1'b0;
      end
   end

   // Grant monitor
   always @(negedge clk) begin
      gnt_t g;
      if (req_ready != '0) begin
         if (exp_gnt.size() == 0) begin
            check("gnt_unexpected", 64'(req_ready), 64'(0));
         end else begin
            g = exp_gnt.pop_front();
            check("gnt_vec", 64'(req_ready), 64'(1 << g.id));
            check("gnt_cyc", 64'(cyc), 64'(g.cyc));
         end
         for (int k = 0; k < NR; k++) if (req_ready[k]) accepted[k]++;
      end
   end

   // Response monitor
   always @(negedge clk) begin
      rsp_t r;
      if (rsp_valid != '0) begin
         if (exp_rsp.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'(0));
         end else begin
            r = exp_rsp.pop_front();
            check("rsp_vec", 64'(rsp_valid), 64'(1 << r.id));
            check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
            check("rsp_err", 64'(rsp_err), 64'(r.err));
            check("rsp_cyc", 64'(cyc), 64'(r.cyc));
         end
      end else begin
         check("rsp_idle", {31'b0, rsp_err, rsp_rdata}, 64'(0));
      end
   end

   // APB monitor: SETUP pops the expected phase, ACCESS must hold it, idle must be all-zero.
   apb_t cur = '{default: '0};
   always @(negedge clk) begin
      if (psel && !penable) begin
         if (exp_apb.size() == 0) begin
            check("apb_unexpected", 64'(psel), 64'(0));
         end else begin
            cur = exp_apb.pop_front();
            check("setup_addr", 64'(paddr), 64'(cur.addr));
            check("setup_write", 64'(pwrite), 64'(cur.wr));
            check("setup_wdata", 64'(pwdata), 64'(cur.wdata));
         end
      end else if (psel && penable) begin
         check("access_addr", 64'(paddr), 64'(cur.addr));
         check("access_write", 64'(pwrite), 64'(cur.wr));
         check("access_wdata", 64'(pwdata), 64'(cur.wdata));
      end else begin
         check("apb_idle", {penable, pwrite, paddr, pwdata[29:0]}, 64'(0));
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(int k, logic wr, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] rd_exp, logic err_exp, int gcyc, int rcyc);
      req_write[k]          = wr;
      req_addr[k*AW +: AW]  = a;
      req_wdata[k*DW +: DW] = wd;
      exp_gnt.push_back('{k, gcyc});
      exp_rsp.push_back('{k, rd_exp, err_exp, rcyc});
      exp_apb.push_back('{a, wr, wr ? wd : 32'h0});
      issued[k]++;
   endtask

   task automatic drain(int budget);
      int n = 0;
      while ((exp_rsp.size() != 0 || exp_gnt.size() != 0) && n < budget) begin
         step(1);
         n++;
      end
      check("drain_timeout", 64'(n >= budget), 64'(0));
      if (n >= budget) begin
         exp_rsp.delete();
         exp_gnt.delete();
         exp_apb.delete();
      end
      step(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      rst       = 1'b1;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      step(2);
      @(negedge clk);
      check("reset_ready", 64'(req_ready), 64'(0));
      check("reset_rsp", 64'(rsp_valid), 64'(0));
      check("reset_apb", {62'b0, psel, penable}, 64'(0));
      step(1);
      rst = 1'b0;
      step(1);

      // Zero-wait write from requester 0
      c = cyc; ws = 0; slv_rdata = 32'h7777_7777; slv_err = 1'b0;
      issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, c, c + 3);
      drain(30);

      // Read from requester 2 with three wait states
      c = cyc; ws = 3; slv_rdata = 32'h1234;
      issue(2, 1'b0, 32'h18, 32'hFFFF_FFFF, 32'h1234, 1'b0, c, c + 6);
      drain(30);

      // All four valid out of reset: 0,1,2,3 then 0 again, four cycles apart
      rst = 1'b1; ws = 0; slv_rdata = 32'h0;
      c = cyc + 2;
      for (int k = 0; k < NR; k++) begin
         issue(k, 1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 32'h0, 1'b0, c + 4 * k, c + 4 * k + 3);
      end
      issue(0, 1'b1, 32'h100, 32'hA0, 32'h0, 1'b0, c + 16, c + 19);
      step(2);
      rst = 1'b0;
      drain(60);

      // Slave error on a read from requester 1 (pointer now 1)
      c = cyc; ws = 1; slv_rdata = 32'h55AA; slv_err = 1'b1;
      issue(1, 1'b0, 32'h24, 32'h0, 32'h55AA, 1'b1, c, c + 4);
      drain(30);
      slv_err = 1'b0;

      // Pointer now 2: requesters 1 and 2 together -> 2 first, then 1
      c = cyc; ws = 0; slv_rdata = 32'h99;
      issue(2, 1'b1, 32'h30, 32'h1111_2222, 32'h0, 1'b0, c, c + 3);
      issue(1, 1'b1, 32'h34, 32'h3333_4444, 32'h0, 1'b0, c + 4, c + 7);
      drain(30);

      // Reset during ACCESS: transaction dropped, pointer back to 0
      c = cyc; ws = 10; slv_rdata = 32'hCAFE;
      issue(2, 1'b0, 32'h40, 32'h0, 32'hCAFE, 1'b0, c, c + 13);
      step(4);
      check("pre_rst_access", {62'b0, psel, penable}, 64'h3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      exp_rsp.delete();
      @(negedge clk);
      check("rst_apb_sel", {62'b0, psel, penable}, 64'(0));
      check("rst_apb_addr", 64'(paddr), 64'(0));
      check("rst_rsp", 64'(rsp_valid), 64'(0));
      step(1);
      c = cyc; ws = 0;
      issue(0, 1'b1, 32'h4C, 32'hA5A5, 32'h0, 1'b0, c, c + 3);
      issue(3, 1'b1, 32'h50, 32'h5A5A, 32'h0, 1'b0, c + 4, c + 7);
      drain(40);

`ifdef APB_ARB_TIMEOUT_EN
      // Slave never ready: abort after TMO ACCESS cycles with error and zero data
      c = cyc; ws = 1000; slv_rdata = 32'hABCD;
      issue(1, 1'b0, 32'h60, 32'h0, 32'h0, 1'b1, c, c + 2 + TMO);
      drain(40);
      ws = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
